dreg_pipe: RTL and testbench
============================

Name: dreg_pipe

Overview:
- Parametrised successor to the single-bit D storage element: a WIDTH-bit, DEPTH-stage edge-triggered register pipeline.
- Each stage carries a valid bit. The pipe has a global advance enable (stall), a synchronous flush and a live occupancy count.
- Used as a configurable delay line / retiming stage between datapath blocks.

Parameters:
- WIDTH, 8, data bits per stage (>=1).
- DEPTH, 4, number of stages = latency in clocks (>=1).
- RESET_VAL, 0, data value loaded into every stage on reset (WIDTH bits).
- OCC_W, $clog2(DEPTH+1), width of the occupancy output (derived; do not override).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  advance enable; 0 = stall, all state held.
- flush  input  1  synchronous clear of all valid bits.
- d  input  WIDTH  data into stage 0.
- d_valid  input  1  qualifies d.
- q  output  WIDTH  data of last stage (DEPTH-1).
- q_valid  output  1  valid bit of last stage.
- occupancy  output  OCC_W  number of stages currently holding valid data (0..DEPTH).

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - all stage data = RESET_VAL; all valid bits = 0; occupancy = 0.
  - Outputs therefore read q=RESET_VAL, q_valid=0, occupancy=0 immediately.
- Deassertion of reset is sampled by the next rising edge. No state changes until that edge.
- Priority at each rising edge with reset=1: flush > en > hold.
- flush=1:
  - all valid bits <= 0; occupancy <= 0.
  - Data registers are not modified.
  - d/d_valid on that edge are discarded, regardless of en.
- flush=0, en=1:
  - stage[0] <= {d_valid, d}; stage[i] <= stage[i-1] for i=1..DEPTH-1.
  - The old last stage is dropped.
- flush=0, en=0: every register holds; d/d_valid ignored.
- Data registers load on every advance, even when d_valid=0. A bubble carries its d value with valid=0.
- Latency: d captured at edge k appears on q at edge k+DEPTH-1, i.e. DEPTH edges after it was presented. With DEPTH=1, q follows d one clock late.
- q and q_valid are straight register outputs, with no combinational path from inputs.
- occupancy:
  - registered counter, updated on advance only: occ_next = occ + d_valid - q_valid (current q_valid).
  - Simultaneous in and out leaves the count unchanged.
  - Never exceeds DEPTH and never underflows; the bench asserts this.
  - Must always equal the popcount of the stage valid bits.
- No backpressure and no overflow condition: the pipe always accepts on advance, and valid data leaving the last stage is lost.
- Reset asserted mid-stream wipes everything asynchronously, including in-flight data. Flush is the synchronous equivalent for valid bits only.

Decomposition:
- Shared header dreg_defs.vh holds the default WIDTH/DEPTH constants and a clog2 constant function, reused by later storage blocks.
- One natural sub-module: dreg_stage, a single WIDTH+1-bit register with enable, synchronous valid-clear and async active-low reset to {0, RESET_VAL}.
- dreg_pipe instantiates DEPTH of these in a generate loop and adds the occupancy counter.

Test Plan:
All scenarios use WIDTH=8, DEPTH=4, RESET_VAL=0.
1. Hold reset=0 for 3 clocks with d=8'hFF, d_valid=1, en=1 -> q=8'h00, q_valid=0, occupancy=0 throughout. Release reset between edges -> no change until the first rising edge.
2. en=1; present 8'hA5, 8'h5A, 8'h3C, 8'hC3 valid on consecutive edges 1-4 ->
   - occupancy 1,2,3,4 after edges 1-4.
   - q=8'hA5 with q_valid=1 after edge 4; q=8'h5A after edge 5, then 8'h3C, 8'hC3.
   - If d_valid=0 from edge 5 on: occupancy 3,2,1,0.
3. Mid-stream (occupancy=2) hold en=0 for 3 clocks while d=8'h77, d_valid=1 -> q, q_valid and occupancy frozen. 8'h77 never appears on q.
4. Full pipe (occupancy=4, q=8'hA5): assert flush=1 with en=1, d=8'h11, d_valid=1 for one edge ->
   - next edge: occupancy=0, q_valid=0, q still 8'hA5.
   - 8'h11 never emerges valid.
5. Alternate d_valid 1,0,1,0 with en=1 from empty -> after 4 edges occupancy toggles between 2 and 2 (steady 2). q_valid pattern repeats the input pattern delayed 4 edges.
6. With occupancy=3, drive reset=0 mid-cycle (not on an edge) -> q=8'h00, q_valid=0, occupancy=0 immediately, before the next rising edge.

Source files
------------

// File: rtl/dreg_pipe_pkg.sv
// dreg_pipe_pkg: shared defaults and constant helpers for the dreg storage blocks.
`default_nettype none

package dreg_pipe_pkg;

  localparam int DREG_DEF_WIDTH = 8;
  localparam int DREG_DEF_DEPTH = 4;

  // Number of bits needed to hold the values 0..value-1.
  function automatic int dreg_clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dreg_pipe_stage.sv
// dreg_stage: one data+valid register with advance enable, synchronous valid clear
// and asynchronous active-low reset to {0, RESET_VAL}.
`default_nettype none

module dreg_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  // Clear only drops the valid bit; the data register keeps its contents.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q       <= RESET_VAL;
      q_valid <= 1'b0;
    end else if (clear) begin
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dreg_pipe.sv
// dreg_pipe: WIDTH-bit, DEPTH-stage register pipeline with per-stage valid bits,
// global stall, synchronous flush and a registered occupancy count.
`default_nettype none

module dreg_pipe
  import dreg_pipe_pkg::*;
#(
  parameter int               WIDTH     = DREG_DEF_WIDTH,
  parameter int               DEPTH     = DREG_DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              OCC_W     = dreg_clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] stage_data  [DEPTH];
  logic             stage_valid [DEPTH];
  logic [OCC_W-1:0] occ;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] in_data;
    logic             in_valid;

    if (i == 0) begin : g_first
      assign in_data  = d;
      assign in_valid = d_valid;
    end else begin : g_next
      assign in_data  = stage_data[i-1];
      assign in_valid = stage_valid[i-1];
    end

    dreg_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .en      (en),
      .clear   (flush),
      .d       (in_data),
      .d_valid (in_valid),
      .q       (stage_data[i]),
      .q_valid (stage_valid[i])
    );
  end

  // Tracks the valid popcount incrementally: one in, one out per advance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else if (en) begin
      occ <= occ + OCC_W'(d_valid) - OCC_W'(stage_valid[DEPTH-1]);
    end
  end

  assign q         = stage_data[DEPTH-1];
  assign q_valid   = stage_valid[DEPTH-1];
  assign occupancy = occ;

endmodule

`default_nettype wire

// File: tb/tb_dreg_pipe.sv
// tb_dreg_pipe: directed, table-driven self-checking bench for dreg_pipe (WIDTH=8, DEPTH=4).
`default_nettype none

module tb_dreg_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic       en;
    logic       flush;
    logic [7:0] d;
    logic       dv;
    logic [7:0] eq;
    logic       eqv;
    logic [2:0] eocc;
    string      name;
  } vec_t;

  logic       clock;
  logic       reset;
  logic       en;
  logic       flush;
  logic [7:0] d;
  logic       d_valid;
  logic [7:0] q;
  logic       q_valid;
  logic [2:0] occupancy;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];

  dreg_pipe #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (8'h00)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .d         (d),
    .d_valid   (d_valid),
    .q         (q),
    .q_valid   (q_valid),
    .occupancy (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Occupancy bound, sampled away from the active edge.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      checks = checks + 1;
      if (occupancy > 3'(DEPTH)) begin
        failures = failures + 1;
        $display("FAIL occ_bound: occupancy=%0d exceeds %0d", occupancy, DEPTH);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] eq, input logic eqv,
                       input logic [2:0] eocc);
    checks = checks + 3;
    if (q !== eq) begin
      failures = failures + 1;
      $display("FAIL %s q: got %02h expected %02h", name, q, eq);
    end
    if (q_valid !== eqv) begin
      failures = failures + 1;
      $display("FAIL %s q_valid: got %b expected %b", name, q_valid, eqv);
    end
    if (occupancy !== eocc) begin
      failures = failures + 1;
      $display("FAIL %s occupancy: got %0d expected %0d", name, occupancy, eocc);
    end
  endtask

  task automatic add(input string name, input logic e, input logic f, input logic [7:0] dd,
                     input logic v, input logic [7:0] eq, input logic eqv,
                     input logic [2:0] eocc);
    vec_t t;
    t.name = name; t.en = e; t.flush = f; t.d = dd; t.dv = v;
    t.eq = eq; t.eqv = eqv; t.eocc = eocc;
    vecs.push_back(t);
  endtask

  initial begin
    // Fill phase and drain with bubbles carrying d=00.
    add("fill1", 1, 0, 8'hA5, 1, 8'h00, 0, 1);
    add("fill2", 1, 0, 8'h5A, 1, 8'h00, 0, 2);
    add("fill3", 1, 0, 8'h3C, 1, 8'h00, 0, 3);
    add("fill4", 1, 0, 8'hC3, 1, 8'hA5, 1, 4);
    add("drain1", 1, 0, 8'h00, 0, 8'h5A, 1, 3);
    add("drain2", 1, 0, 8'h00, 0, 8'h3C, 1, 2);
    add("drain3", 1, 0, 8'h00, 0, 8'hC3, 1, 1);
    add("drain4", 1, 0, 8'h00, 0, 8'h00, 0, 0);
    // Stall with occupancy 2; 0x77 must never be captured.
    add("st_fill1", 1, 0, 8'hA5, 1, 8'h00, 0, 1);
    add("st_fill2", 1, 0, 8'h5A, 1, 8'h00, 0, 2);
    add("stall1", 0, 0, 8'h77, 1, 8'h00, 0, 2);
    add("stall2", 0, 0, 8'h77, 1, 8'h00, 0, 2);
    add("stall3", 0, 0, 8'h77, 1, 8'h00, 0, 2);
    add("st_go1", 1, 0, 8'h00, 0, 8'h00, 0, 2);
    add("st_go2", 1, 0, 8'h00, 0, 8'hA5, 1, 2);
    add("st_go3", 1, 0, 8'h00, 0, 8'h5A, 1, 1);
    add("st_go4", 1, 0, 8'h00, 0, 8'h00, 0, 0);
    // Flush a full pipe; data stays, valids clear, 0x11 is dropped.
    add("fl_fill1", 1, 0, 8'hA5, 1, 8'h00, 0, 1);
    add("fl_fill2", 1, 0, 8'h5A, 1, 8'h00, 0, 2);
    add("fl_fill3", 1, 0, 8'h3C, 1, 8'h00, 0, 3);
    add("fl_fill4", 1, 0, 8'hC3, 1, 8'hA5, 1, 4);
    add("flush", 1, 1, 8'h11, 1, 8'hA5, 0, 0);
    add("fl_after1", 1, 0, 8'h00, 0, 8'h5A, 0, 0);
    add("fl_after2", 1, 0, 8'h00, 0, 8'h3C, 0, 0);
    add("fl_after3", 1, 0, 8'h00, 0, 8'hC3, 0, 0);
    add("fl_after4", 1, 0, 8'h00, 0, 8'h00, 0, 0);
    // Alternating valid from empty: steady occupancy 2 after 4 edges.
    add("alt1", 1, 0, 8'h01, 1, 8'h00, 0, 1);
    add("alt2", 1, 0, 8'h02, 0, 8'h00, 0, 1);
    add("alt3", 1, 0, 8'h03, 1, 8'h00, 0, 2);
    add("alt4", 1, 0, 8'h04, 0, 8'h01, 1, 2);
    add("alt5", 1, 0, 8'h05, 1, 8'h02, 0, 2);
    add("alt6", 1, 0, 8'h06, 0, 8'h03, 1, 2);
    add("alt7", 1, 0, 8'h07, 1, 8'h04, 0, 2);
    add("alt8", 1, 0, 8'h08, 0, 8'h05, 1, 2);
    // Flush, then load three for the async reset test.
    add("pre_rst_fl", 1, 1, 8'h00, 0, 8'h05, 0, 0);
    add("pre_rst1", 1, 0, 8'hE1, 1, 8'h06, 0, 1);
    add("pre_rst2", 1, 0, 8'hE2, 1, 8'h07, 0, 2);
    add("pre_rst3", 1, 0, 8'hE3, 1, 8'h08, 0, 3);

    // Reset held with active-looking inputs.
    reset = 1'b0; en = 1'b1; flush = 1'b0; d = 8'hFF; d_valid = 1'b1;
    #1 check("rst_async", 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("rst_hold", 8'h00, 0, 0);
    end
    @(negedge clock);
    reset = 1'b1;
    #1 check("rst_release", 8'h00, 0, 0);
    #3 check("rst_pre_edge", 8'h00, 0, 0);
    en = 1'b0;
    @(posedge clock); #1;
    check("rst_first_edge", 8'h00, 0, 0);

    foreach (vecs[i]) begin
      en = vecs[i].en; flush = vecs[i].flush; d = vecs[i].d; d_valid = vecs[i].dv;
      @(posedge clock); #1;
      check(vecs[i].name, vecs[i].eq, vecs[i].eqv, vecs[i].eocc);
    end

    // Asynchronous reset mid-cycle with occupancy 3.
    en = 1'b0; flush = 1'b0; d = 8'h00; d_valid = 1'b0;
    #2 reset = 1'b0;
    #1 check("rst_midcycle", 8'h00, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst_mid_after", 8'h00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
